// File: rtl/watch_time_counter.sv
// watch_time_counter: BCD hours:minutes timekeeper.
// Advances by one minute per one_minute tick and accepts validated time loads.
// Supports a 24h build (00..23) and a 12h build (01..12 with pm flag).
// Every output comes straight from a register. The three pulse outputs are
// high for one cycle only.

module watch_time_counter #(
  parameter int unsigned HOUR_MODE_24 = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_one_minute,
  input  logic        i_load_new_time,
  input  logic [15:0] i_new_time,
  output logic [3:0]  o_hour_ms,
  output logic [3:0]  o_hour_ls,
  output logic [3:0]  o_min_ms,
  output logic [3:0]  o_min_ls,
  output logic        o_pm,
  output logic        o_time_updated,
  output logic        o_day_rollover,
  output logic        o_load_error
);

  // Midnight is shown as 00:00 in the 24h build and as 12:00 (am) in the 12h build.
  localparam logic [3:0] RstHourMs = (HOUR_MODE_24 != 0) ? 4'd0 : 4'd1;
  localparam logic [3:0] RstHourLs = (HOUR_MODE_24 != 0) ? 4'd0 : 4'd2;

  logic [3:0] r_hour_ms;
  logic [3:0] r_hour_ls;
  logic [3:0] r_min_ms;
  logic [3:0] r_min_ls;
  logic       r_pm;
  logic       r_time_updated;
  logic       r_day_rollover;
  logic       r_load_error;

  logic [3:0] w_inc_hour_ms;
  logic [3:0] w_inc_hour_ls;
  logic [3:0] w_inc_min_ms;
  logic [3:0] w_inc_min_ls;
  logic       w_inc_pm;
  logic       w_inc_rollover;

  logic [3:0] w_ld_hour_ms;
  logic [3:0] w_ld_hour_ls;
  logic [3:0] w_ld_min_ms;
  logic [3:0] w_ld_min_ls;
  logic       w_ld_digits_ok;
  logic       w_ld_hours_ok;
  logic       w_ld_valid;
  logic       w_ld_pm;

  // True when a BCD hour pair (assumed in range 00..23) is 12 or later.
  function automatic logic hours_ge_12(input logic [3:0] ms, input logic [3:0] ls);
    return (ms >= 4'd2) || ((ms == 4'd1) && (ls >= 4'd2));
  endfunction

  assign w_ld_hour_ms = i_new_time[15:12];
  assign w_ld_hour_ls = i_new_time[11:8];
  assign w_ld_min_ms  = i_new_time[7:4];
  assign w_ld_min_ls  = i_new_time[3:0];

  // Validate the load word: BCD digits, minutes 00..59, hours within the build's range.
  always_comb begin
    w_ld_digits_ok = (w_ld_hour_ms <= 4'd9) && (w_ld_hour_ls <= 4'd9) &&
                     (w_ld_min_ms <= 4'd5) && (w_ld_min_ls <= 4'd9);
    if (HOUR_MODE_24 != 0) begin
      w_ld_hours_ok = (w_ld_hour_ms < 4'd2) ||
                      ((w_ld_hour_ms == 4'd2) && (w_ld_hour_ls <= 4'd3));
      w_ld_pm       = hours_ge_12(w_ld_hour_ms, w_ld_hour_ls);
    end else begin
      w_ld_hours_ok = ((w_ld_hour_ms == 4'd0) && (w_ld_hour_ls != 4'd0)) ||
                      ((w_ld_hour_ms == 4'd1) && (w_ld_hour_ls <= 4'd2));
      // A 12h load sets the clock face only; am/pm stays as it was.
      w_ld_pm       = r_pm;
    end
    w_ld_valid = w_ld_digits_ok && w_ld_hours_ok;
  end

  // One-minute increment with BCD carries through minutes and hours.
  always_comb begin
    w_inc_hour_ms  = r_hour_ms;
    w_inc_hour_ls  = r_hour_ls;
    w_inc_min_ms   = r_min_ms;
    w_inc_min_ls   = r_min_ls;
    w_inc_pm       = r_pm;
    w_inc_rollover = 1'b0;

    if (r_min_ls != 4'd9) begin
      w_inc_min_ls = r_min_ls + 4'd1;
    end else begin
      w_inc_min_ls = 4'd0;
      if (r_min_ms != 4'd5) begin
        w_inc_min_ms = r_min_ms + 4'd1;
      end else begin
        w_inc_min_ms = 4'd0;
        if (HOUR_MODE_24 != 0) begin
          if ((r_hour_ms == 4'd2) && (r_hour_ls == 4'd3)) begin
            w_inc_hour_ms  = 4'd0;
            w_inc_hour_ls  = 4'd0;
            w_inc_rollover = 1'b1;
          end else if (r_hour_ls == 4'd9) begin
            w_inc_hour_ms = r_hour_ms + 4'd1;
            w_inc_hour_ls = 4'd0;
          end else begin
            w_inc_hour_ls = r_hour_ls + 4'd1;
          end
        end else begin
          if ((r_hour_ms == 4'd1) && (r_hour_ls == 4'd2)) begin
            // 12 -> 01 does not touch am/pm.
            w_inc_hour_ms = 4'd0;
            w_inc_hour_ls = 4'd1;
          end else if ((r_hour_ms == 4'd1) && (r_hour_ls == 4'd1)) begin
            // 11 -> 12 flips am/pm; pm->am is the start of a new day.
            w_inc_hour_ms  = 4'd1;
            w_inc_hour_ls  = 4'd2;
            w_inc_pm       = ~r_pm;
            w_inc_rollover = r_pm;
          end else if (r_hour_ls == 4'd9) begin
            w_inc_hour_ms = r_hour_ms + 4'd1;
            w_inc_hour_ls = 4'd0;
          end else begin
            w_inc_hour_ls = r_hour_ls + 4'd1;
          end
        end
      end
    end

    if (HOUR_MODE_24 != 0) begin
      w_inc_pm = hours_ge_12(w_inc_hour_ms, w_inc_hour_ls);
    end
  end

  // Time and pulse registers: load has priority over tick; a coincident tick is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hour_ms      <= RstHourMs;
      r_hour_ls      <= RstHourLs;
      r_min_ms       <= 4'd0;
      r_min_ls       <= 4'd0;
      r_pm           <= 1'b0;
      r_time_updated <= 1'b0;
      r_day_rollover <= 1'b0;
      r_load_error   <= 1'b0;
    end else begin
      r_time_updated <= 1'b0;
      r_day_rollover <= 1'b0;
      r_load_error   <= 1'b0;
      if (i_load_new_time) begin
        if (w_ld_valid) begin
          r_hour_ms      <= w_ld_hour_ms;
          r_hour_ls      <= w_ld_hour_ls;
          r_min_ms       <= w_ld_min_ms;
          r_min_ls       <= w_ld_min_ls;
          r_pm           <= w_ld_pm;
          r_time_updated <= 1'b1;
        end else begin
          r_load_error <= 1'b1;
        end
      end else if (i_one_minute) begin
        r_hour_ms      <= w_inc_hour_ms;
        r_hour_ls      <= w_inc_hour_ls;
        r_min_ms       <= w_inc_min_ms;
        r_min_ls       <= w_inc_min_ls;
        r_pm           <= w_inc_pm;
        r_time_updated <= 1'b1;
        r_day_rollover <= w_inc_rollover;
      end
    end
  end

  assign o_hour_ms      = r_hour_ms;
  assign o_hour_ls      = r_hour_ls;
  assign o_min_ms       = r_min_ms;
  assign o_min_ls       = r_min_ls;
  assign o_pm           = r_pm;
  assign o_time_updated = r_time_updated;
  assign o_day_rollover = r_day_rollover;
  assign o_load_error   = r_load_error;

endmodule

// File: tb/tb_watch_time_counter.sv
// Bench for watch_time_counter: a 24h and a 12h instance share one stimulus stream.
// The reference model keeps time as minutes since midnight and derives the display from that.

module tb_watch_time_counter;

  logic        clk;
  logic        rst_n;
  logic        one_minute;
  logic        load;
  logic [15:0] new_time;

  logic [3:0] hms24, hls24, mms24, mls24;
  logic       pm24, upd24, roll24, err24;
  logic [3:0] hms12, hls12, mms12, mls12;
  logic       pm12, upd12, roll12, err12;

  watch_time_counter #(.HOUR_MODE_24(1)) u_dut24 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_one_minute   (one_minute),
    .i_load_new_time(load),
    .i_new_time     (new_time),
    .o_hour_ms      (hms24),
    .o_hour_ls      (hls24),
    .o_min_ms       (mms24),
    .o_min_ls       (mls24),
    .o_pm           (pm24),
    .o_time_updated (upd24),
    .o_day_rollover (roll24),
    .o_load_error   (err24)
  );

  watch_time_counter #(.HOUR_MODE_24(0)) u_dut12 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_one_minute   (one_minute),
    .i_load_new_time(load),
    .i_new_time     (new_time),
    .o_hour_ms      (hms12),
    .o_hour_ls      (hls12),
    .o_min_ms       (mms12),
    .o_min_ls       (mls12),
    .o_pm           (pm12),
    .o_time_updated (upd12),
    .o_day_rollover (roll12),
    .o_load_error   (err12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Model state, index 0 = 12h build, index 1 = 24h build.
  int mins[2];
  bit eu[2];
  bit er[2];
  bit ee[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit load_ok(input int mode, input logic [15:0] nt);
    int h;
    if (nt[15:12] > 9 || nt[11:8] > 9 || nt[7:4] > 5 || nt[3:0] > 9) return 1'b0;
    h = int'(nt[15:12]) * 10 + int'(nt[11:8]);
    if (mode == 1) return h <= 23;
    return (h >= 1) && (h <= 12);
  endfunction

  function automatic logic [15:0] exp_disp(input int mode, input int mn);
    int h;
    int mi;
    h  = mn / 60;
    mi = mn % 60;
    if (mode == 0) begin
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mins[m] = 0;
      eu[m] = 0;
      er[m] = 0;
      ee[m] = 0;
    end
  endtask

  task automatic model_edge(input bit ld, input logic [15:0] nt, input bit tk);
    int h;
    int mi;
    for (int m = 0; m < 2; m++) begin
      eu[m] = 0;
      er[m] = 0;
      ee[m] = 0;
      if (ld) begin
        if (load_ok(m, nt)) begin
          h  = int'(nt[15:12]) * 10 + int'(nt[11:8]);
          mi = int'(nt[7:4]) * 10 + int'(nt[3:0]);
          if (m == 1) mins[m] = h * 60 + mi;
          else mins[m] = ((h % 12) + ((mins[m] >= 720) ? 12 : 0)) * 60 + mi;
          eu[m] = 1;
        end else begin
          ee[m] = 1;
        end
      end else if (tk) begin
        mins[m] = (mins[m] + 1) % 1440;
        eu[m] = 1;
        er[m] = (mins[m] == 0);
      end
    end
  endtask

  task automatic check_all();
    check("disp24", {hms24, hls24, mms24, mls24}, exp_disp(1, mins[1]));
    check("pm24", pm24, mins[1] >= 720);
    check("upd24", upd24, eu[1]);
    check("roll24", roll24, er[1]);
    check("err24", err24, ee[1]);
    check("disp12", {hms12, hls12, mms12, mls12}, exp_disp(0, mins[0]));
    check("pm12", pm12, mins[0] >= 720);
    check("upd12", upd12, eu[0]);
    check("roll12", roll12, er[0]);
    check("err12", err12, ee[0]);
  endtask

  // One clock: drive inputs, let the edge happen, update the model, sample 1 time unit later.
  task automatic step(input bit ld, input logic [15:0] nt, input bit tk);
    load       = ld;
    new_time   = nt;
    one_minute = tk;
    @(posedge clk);
    model_edge(ld, nt, tk);
    #1;
    check_all();
  endtask

  // Async reset between edges while a tick is held high; reset is held across one edge.
  task automatic reset_mid();
    one_minute = 1'b1;
    load       = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_disp24", {hms24, hls24, mms24, mls24}, 16'h0000);
    check("rst_disp12", {hms12, hls12, mms12, mls12}, 16'h1200);
    @(posedge clk);
    #1;
    check_all();
    #2 rst_n = 1'b1;
  endtask

  int cnt24;
  int cnt12;
  logic [15:0] rnd_nt;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    one_minute = 1'b0;
    load       = 1'b0;
    new_time   = 16'h0;
    model_reset();

    // Reset state of both builds.
    #7;
    check_all();
    check("t1_rst24", {hms24, hls24, mms24, mls24}, 16'h0000);
    check("t1_rst12", {hms12, hls12, mms12, mls12, 3'b000, pm12}, 20'h12000);
    #5 rst_n = 1'b1;

    // First tick after reset, then pulse must drop.
    step(1'b0, 16'h0, 1'b1);
    check("t1_tick24", {hms24, hls24, mms24, mls24, 3'b000, upd24}, 20'h00011);
    step(1'b0, 16'h0, 1'b0);

    // 23:59 -> 00:00 with rollover.
    step(1'b1, 16'h2359, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    check("t2_wrap24", {hms24, hls24, mms24, mls24, 2'b00, upd24, roll24}, 20'h00003);

    // Hour carries and 24h pm.
    step(1'b1, 16'h0959, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    check("t3_1000", {hms24, hls24, mms24, mls24}, 16'h1000);
    step(1'b1, 16'h1159, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    check("t3_1200", {hms24, hls24, mms24, mls24, 3'b000, pm24}, 20'h12001);

    // Invalid loads leave time alone.
    step(1'b1, 16'h2460, 1'b0);
    check("t4_err_a", err24, 1'b1);
    step(1'b1, 16'h1A00, 1'b0);
    check("t4_err_b", {hms24, hls24, mms24, mls24, 2'b00, err24, upd24}, 20'h12002);

    // Load beats a coincident tick.
    step(1'b1, 16'h0830, 1'b1);
    check("t5_0830", {hms24, hls24, mms24, mls24}, 16'h0830);

    // 12h scenarios from reset.
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    reset_mid();
    step(1'b1, 16'h1159, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    check("t6_noon12", {hms12, hls12, mms12, mls12, 3'b000, pm12}, 20'h12001);
    step(1'b1, 16'h1259, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    check("t6_0100pm", {hms12, hls12, mms12, mls12, 3'b000, pm12}, 20'h01001);
    step(1'b1, 16'h1159, 1'b0);
    step(1'b0, 16'h0, 1'b1);
    check("t6_midn12", {hms12, hls12, mms12, mls12, 2'b00, pm12, roll12}, 20'h12001);

    // Full day of ticks from midnight.
    reset_mid();
    cnt24 = 0;
    cnt12 = 0;
    for (int i = 0; i < 1440; i++) begin
      step(1'b0, 16'h0, 1'b1);
      if (roll24) cnt24++;
      if (roll12) cnt12++;
    end
    check("t8_rolls24", cnt24, 1);
    check("t8_rolls12", cnt12, 1);
    check("t8_end24", {hms24, hls24, mms24, mls24}, 16'h0000);
    check("t8_end12", {hms12, hls12, mms12, mls12, 3'b000, pm12}, 20'h12000);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 0) rnd_nt = 16'($urandom);
      else rnd_nt = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 299) == 0) reset_mid();
      else step($urandom_range(0, 7) == 0, rnd_nt, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
